// File: rtl/wb_pkg.sv
// Shared Wishbone B3 encodings and the two-master arbiter state type.
package wb_pkg;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] CONST   = 3'b001;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    localparam logic [1:0] LINEAR  = 2'b00;
    localparam logic [1:0] WRAP4   = 2'b01;
    localparam logic [1:0] WRAP8   = 2'b10;
    localparam logic [1:0] WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Counts consecutive strobe cycles without a slave response and flags expiry
// combinationally on the cycle the count reaches timeout_cycles.
module wb_arb_watchdog
    import wb_pkg::*;
#(
    parameter int unsigned timeout_cycles = 255,
    parameter int unsigned tmo_w          = 8
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam logic [tmo_w-1:0] SAT  = tmo_w'(timeout_cycles);
    localparam logic [tmo_w-1:0] LAST = tmo_w'((timeout_cycles == 0) ? 0 : timeout_cycles - 1);

    logic [tmo_w-1:0] cnt;
    logic             waiting;

    assign waiting = en && !clr;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt <= '0;
        end else if (!waiting) begin
            cnt <= '0;
        end else if (cnt != SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of already-elapsed waiting cycles, so the current
    // cycle is number cnt+1; a response arriving now suppresses expiry.
    assign expire = (timeout_cycles != 0) && waiting && (cnt == LAST);

endmodule

// File: rtl/wb_ram_arb2.sv
// Two-master Wishbone B3 arbiter in front of one RAM slave: whole-cycle
// grants, round-robin on ties, per-grant watchdog that aborts hung cycles.
module wb_ram_arb2
    import wb_pkg::*;
#(
    parameter int unsigned dw             = 32,
    parameter int unsigned aw             = 32,
    parameter int unsigned timeout_cycles = 255,
    parameter int unsigned tmo_w          = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] m0_adr_i,
    input  logic [dw-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    output logic [dw-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_rty_o,
    input  logic [aw-1:0] m1_adr_i,
    input  logic [dw-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    output logic [dw-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_rty_o,
    output logic [aw-1:0] s_adr_o,
    output logic [dw-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    input  logic [dw-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_rty_i,
    output logic [1:0]    grant_o,
    output logic          tmo_o
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       cur_q, cur_d;
    logic       wd_en, expire;
    logic       unused_rty;

    // Retry is never forwarded; the RAM slave does not issue it.
    assign unused_rty = s_rty_i;
    assign m0_rty_o   = 1'b0;
    assign m1_rty_o   = 1'b0;
    assign m0_dat_o   = s_dat_i;
    assign m1_dat_o   = s_dat_i;

    // Derived from state and master inputs rather than s_stb_o to keep the
    // watchdog out of the output mux's combinational path.
    assign wd_en = ((state_q == OWN0) && m0_stb_i) || ((state_q == OWN1) && m1_stb_i);

    wb_arb_watchdog #(
        .timeout_cycles(timeout_cycles),
        .tmo_w         (tmo_w)
    ) u_watchdog (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .en      (wd_en),
        .clr     (s_ack_i || s_err_i),
        .expire  (expire)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cur_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE: begin
                if ((m0_cyc_i && m1_cyc_i && last_q) || (m0_cyc_i && !m1_cyc_i)) begin
                    state_d = OWN0;
                    cur_d   = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                    cur_d   = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (expire) begin
                    state_d = ABORT;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else if (expire) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (!(cur_q ? m1_cyc_i : m0_cyc_i)) begin
                    state_d = IDLE;
                    last_d  = cur_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_cti_o  = CLASSIC;
        s_bte_o  = LINEAR;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        grant_o  = 2'b00;
        tmo_o    = 1'b0;
        case (state_q)
            OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || expire;
                grant_o  = 2'b01;
                tmo_o    = expire;
            end
            OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || expire;
                grant_o  = 2'b10;
                tmo_o    = expire;
            end
            ABORT:   grant_o = cur_q ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_ram_arb2.sv
// Directed self-checking bench for wb_ram_arb2 with a 16-cycle watchdog.
module tb_wb_ram_arb2;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m0_dat_i, m0_dat_o, m1_adr, m1_dat_i, m1_dat_o;
    logic [3:0]  m0_sel, m1_sel, s_sel_o;
    logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err, m0_rty;
    logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err, m1_rty;
    logic [2:0]  m0_cti, m1_cti, s_cti_o;
    logic [1:0]  m0_bte, m1_bte, s_bte_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  grant_o;
    logic        tmo_o;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_ram_arb2 #(
        .dw(32), .aw(32), .timeout_cycles(16), .tmo_w(8)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .tmo_o(tmo_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_adr = '0; m0_dat_i = '0; m0_sel = 4'hf; m0_we = 0; m0_cyc = 0; m0_stb = 0;
        m0_cti = CLASSIC; m0_bte = LINEAR;
        m1_adr = '0; m1_dat_i = '0; m1_sel = 4'hf; m1_we = 0; m1_cyc = 0; m1_stb = 0;
        m1_cti = CLASSIC; m1_bte = LINEAR;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
        tick();
        tick();
        chk("rst_scyc", s_cyc_o, 0);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_acks", {m1_ack, m0_ack, m1_err, m0_err}, 4'b0);
        chk("rst_tmo", tmo_o, 0);
        rst = 1'b0;
        tick();

        // Single master classic read
        m0_adr = 32'h100; m0_cyc = 1; m0_stb = 1;
        #1;
        chk("t1_latency_scyc", s_cyc_o, 0);
        tick();
        chk("t1_scyc", s_cyc_o, 1);
        chk("t1_grant", grant_o, 2'b01);
        chk("t1_sadr", s_adr_o, 32'h100);
        s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
        #1;
        chk("t1_m0ack", m0_ack, 1);
        chk("t1_m0dat", m0_dat_o, 32'hDEADBEEF);
        chk("t1_m1ack", m1_ack, 0);
        tick();
        m0_cyc = 0; m0_stb = 0; s_ack_i = 0;
        #1;
        chk("t1_drop_scyc", s_cyc_o, 0);
        tick();
        chk("t1_idle_grant", grant_o, 2'b00);

        // Contention straight after reset: m0 first, bubble, then m1
        pulse_rst();
        m0_adr = 32'h200; m0_cyc = 1; m0_stb = 1;
        m1_adr = 32'h300; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("t2_first_grant", grant_o, 2'b01);
        chk("t2_sadr0", s_adr_o, 32'h200);
        s_ack_i = 1;
        #1;
        chk("t2_acks", {m1_ack, m0_ack}, 2'b01);
        tick();
        m0_cyc = 0; m0_stb = 0; s_ack_i = 0;
        tick();
        chk("t2_bubble_grant", grant_o, 2'b00);
        chk("t2_bubble_scyc", s_cyc_o, 0);
        tick();
        chk("t2_second_grant", grant_o, 2'b10);
        chk("t2_sadr1", s_adr_o, 32'h300);
        m1_cyc = 0; m1_stb = 0;
        tick();

        // m1 8-beat INCR burst with m0 waiting and one stb gap
        m1_adr = 32'h400; m1_cyc = 1; m1_stb = 1; m1_cti = INCR; m1_bte = WRAP8;
        tick();
        chk("t3_grant_m1", grant_o, 2'b10);
        m0_adr = 32'h500; m0_cyc = 1; m0_stb = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                m1_stb = 0; s_ack_i = 0;
                #1;
                chk("t3_gap_grant", grant_o, 2'b10);
                tick();
                m1_stb = 1;
            end
            m1_adr = 32'h400 + 32'(4 * i);
            m1_cti = (i == 7) ? EOB : INCR;
            s_ack_i = 1;
            #1;
            chk("t3_beat_acks", {m1_ack, m0_ack}, 2'b10);
            chk("t3_beat_cti", s_cti_o, m1_cti);
            chk("t3_beat_bte", s_bte_o, WRAP8);
            tick();
        end
        m1_cyc = 0; m1_stb = 0; m1_cti = CLASSIC; m1_bte = LINEAR; s_ack_i = 0;
        #1;
        chk("t3_end_grant", grant_o, 2'b10);
        tick();
        chk("t3_bubble_grant", grant_o, 2'b00);
        tick();
        chk("t3_m0_grant", grant_o, 2'b01);
        chk("t3_m0_sadr", s_adr_o, 32'h500);
        m0_cyc = 0; m0_stb = 0;
        tick();

        // Round-robin with both masters continuously requesting
        pulse_rst();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t4_rr_grant", grant_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            s_ack_i = 1;
            #1;
            chk("t4_rr_acks", {m1_ack, m0_ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            s_ack_i = 0;
            if (k % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
            else begin m1_cyc = 0; m1_stb = 0; end
            tick();
            chk("t4_rr_bubble", {s_cyc_o, grant_o}, 3'b000);
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        // Watchdog: no response to m0, expiry on the 16th strobe cycle
        m0_adr = 32'h600; m0_cyc = 1; m0_stb = 1;
        m1_adr = 32'h700;
        tick();
        for (int c = 1; c < 16; c++) begin
            chk("t5_no_tmo_yet", {tmo_o, m0_err}, 2'b00);
            tick();
        end
        chk("t5_expire", {tmo_o, m0_err}, 2'b11);
        chk("t5_expire_scyc", s_cyc_o, 1);
        m1_cyc = 1; m1_stb = 1;
        tick();
        chk("t5_abort_bus", {s_cyc_o, s_stb_o}, 2'b00);
        chk("t5_abort_pulse", {tmo_o, m0_err, m1_ack}, 3'b000);
        tick();
        chk("t5_abort_hold", s_cyc_o, 0);
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("t5_idle_grant", grant_o, 2'b00);
        tick();
        chk("t5_m1_grant", grant_o, 2'b10);
        chk("t5_m1_sadr", s_adr_o, 32'h700);
        m1_cyc = 0; m1_stb = 0;
        tick();

        // Ack on the expiry cycle wins, and the count restarts from zero
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int c = 1; c < 16; c++) tick();
        s_ack_i = 1;
        #1;
        chk("t5b_ack_wins", {m0_ack, m0_err, tmo_o}, 3'b100);
        tick();
        s_ack_i = 0;
        for (int c = 1; c < 16; c++) tick();
        chk("t5b_fresh_expire", {tmo_o, m0_err}, 2'b11);
        m0_cyc = 0; m0_stb = 0;
        tick();
        tick();

        // Async reset during beat 3 of an m0 burst
        m0_cyc = 1; m0_stb = 1; m0_cti = INCR;
        tick();
        s_ack_i = 1;
        tick();
        tick();
        chk("t6_beat3_ack", m0_ack, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_bus", {s_cyc_o, s_stb_o, grant_o}, 4'b0000);
        chk("t6_rst_acks", {m0_ack, m1_ack}, 2'b00);
        m0_cyc = 0; m0_stb = 0; m0_cti = CLASSIC; s_ack_i = 0;
        m1_cyc = 1; m1_stb = 1;
        rst = 1'b0;
        tick();
        chk("t6_m1_grant", grant_o, 2'b10);
        chk("t6_m1_scyc", s_cyc_o, 1);
        m1_cyc = 0; m1_stb = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_ram_arb2.md
Name: wb_ram_arb2

Overview:
- Two-master Wishbone B3 arbiter that shares one single-port RAM slave (the ram_wb_b3 block) between a CPU instruction port and a data/debug port.
- Grants whole bus cycles (cyc-bounded), so classic and registered-feedback bursts are never split.
- Round-robin fairness.
- Per-grant watchdog terminates hung cycles with an error.

Parameters:
- dw, 32, data width.
- aw, 32, address width.
- timeout_cycles, 255, max cycles stb may wait for ack/err before forced error; 0 disables watchdog.
- tmo_w, 8, watchdog counter width; must be >= clog2(timeout_cycles+1).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- m0_adr_i/m1_adr_i  in  aw  master address.
- m0_dat_i/m1_dat_i  in  dw  master write data.
- m0_sel_i/m1_sel_i  in  4  byte selects.
- m0_we_i/m1_we_i  in  1  write enable.
- m0_cyc_i/m1_cyc_i  in  1  cycle request.
- m0_stb_i/m1_stb_i  in  1  strobe.
- m0_cti_i/m1_cti_i  in  3  cycle type.
- m0_bte_i/m1_bte_i  in  2  burst type.
- m0_dat_o/m1_dat_o  out  dw  read data.
- m0_ack_o/m1_ack_o  out  1  ack.
- m0_err_o/m1_err_o  out  1  error.
- m0_rty_o/m1_rty_o  out  1  retry, tied 0.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  slave-side copies of the above.
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  slave responses.
- grant_o  out  2  one-hot current owner, for debug.
- tmo_o  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset is async, active-high. Resets:
  - state to IDLE;
  - last_owner to 1, so m0 wins the first tie;
  - watchdog counter to 0;
  - all *_ack_o, *_err_o, s_cyc_o, s_stb_o, grant_o and tmo_o to 0.
- States: IDLE, OWN0, OWN1, ABORT.
- IDLE:
  - Slave cyc/stb are 0.
  - If exactly one mN_cyc_i is high, go to OWNN on the next edge.
  - If both are high, grant the master that is not last_owner.
  - Grant latency is 1 cycle from cyc to s_cyc_o.
- OWNN:
  - All s_* outputs are driven combinationally from master N.
  - mN_dat_o = s_dat_i; mN_ack_o = s_ack_i; mN_err_o = s_err_i.
  - The non-owner sees ack/err = 0. Its dat_o is don't-care and is driven as s_dat_i.
  - Leave to IDLE on the edge where mN_cyc_i is sampled low, and set last_owner = N.
  - Burst cti/bte pass through unchanged. No re-arbitration mid-cycle, including between back-to-back stb gaps while cyc stays high.
- Owner-change bubble: at least one IDLE cycle with s_cyc_o = 0 separates different owners, because the slave's burst tracking keys off cyc/stb.
- Same master re-requesting:
  - If the other master is idle, the same master may re-acquire after that one IDLE cycle.
  - If both are requesting, the other master wins.
- Watchdog:
  - In OWNN, the counter increments each cycle that s_stb_o = 1 and s_ack_i = 0 and s_err_i = 0.
  - It clears on any ack or err, and whenever stb is low.
  - When the count reaches timeout_cycles:
    - assert mN_err_o for exactly one cycle and pulse tmo_o;
    - force s_cyc_o/s_stb_o low from the next cycle;
    - go to ABORT.
- ABORT:
  - Slave outputs inactive; master acks and errors are 0.
  - Hold until mN_cyc_i goes low, then go to IDLE with last_owner = N.
- Simultaneous events:
  - An ack arriving on the expiry cycle wins: no error, counter clears.
  - Owner dropping cyc on the same cycle the other master raises cyc: IDLE, then the other master is granted.
- Mid-operation reset: the bus is released immediately (async); a partial burst is not resumed.
- Width rules: the counter saturates at timeout_cycles and never wraps.

Decomposition:
- Shared package wb_pkg:
  - Wishbone cti constants: CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, EOB=3'b111.
  - bte constants.
  - Arbiter state encoding.
- One sub-module: wb_arb_watchdog (counter, clear/enable/expire). The mux and FSM stay in the top module.

Test Plan:
- Single master, classic read: m0 reads 0x100 with cyc/stb held → s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o follows s_ack_i; m1 ack stays 0.
- Contention: m0 and m1 raise cyc on the same cycle after reset → m0 granted first; after m0 drops cyc, one IDLE cycle, then grant_o = 2'b10.
- Burst integrity: m1 issues an 8-beat INCR (cti=010, bte=10) ending with cti=111 while m0 requests → all 8 acks go to m1; m0 granted only after m1_cyc_i falls.
- Round-robin: both masters hold cyc and issue 4 back-to-back single cycles each → grants alternate 0,1,0,1, each separated by one IDLE cycle.
- Watchdog: timeout_cycles=16, slave never acks m0 → m0_err_o and tmo_o high exactly on cycle 16 of stb; s_cyc_o low next cycle; m1 grantable after m0 drops cyc.
- Async reset mid-burst: assert wb_rst_i during beat 3 of an m0 burst → s_cyc_o and all acks 0 immediately; after release with m1 requesting, m1 is granted.
